// File: rtl/rob_retire_pkg.sv
// Shared sizing and types for the reorder buffer / retirement slice.
// Aliases are {old dest, old flags} physical register pairs handed back to the free list.
package rob_retire_pkg;

    localparam int PR_ADDR_W    = 7;
    localparam int FETCH_WIDTH  = 4;
    localparam int RETIRE_WIDTH = 3;
    localparam int CMPLT_PORTS  = 5;
    localparam int ROB_DEPTH    = 32;
    localparam int ROB_ADDR_W   = 5;

    localparam int ALIAS_W = 2 * PR_ADDR_W;
    localparam int CNT_W   = ROB_ADDR_W + 1;
    localparam int N_W     = $clog2(RETIRE_WIDTH + 1);

    typedef logic [ROB_ADDR_W-1:0] rob_idx_t;
    typedef logic [CNT_W-1:0]      rob_cnt_t;
    typedef logic [N_W-1:0]        ret_cnt_t;
    typedef logic [ALIAS_W-1:0]    alias_pair_t;

    // Physical register 0 is a constant register, so an all-zero pair means "nothing freed".
    localparam alias_pair_t PR_NONE = '0;

    // Ring-buffer offset; wraps naturally because ROB_DEPTH is a power of two.
    function automatic rob_idx_t rob_add(rob_idx_t base, int unsigned off);
        return base + rob_idx_t'(off);
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Retire selection: counts the run of valid & done entries starting at head,
// capped at RETIRE_WIDTH and at the current occupancy.
module retire_select
    import rob_retire_pkg::*;
(
    input  logic [ROB_DEPTH-1:0]    ready_bits,
    input  rob_idx_t                head,
    input  rob_cnt_t                count,
    output ret_cnt_t                n,
    output logic [RETIRE_WIDTH-1:0] lane_en
);

    logic run;

    // NOTE: every output and temporary gets a default before the loop, so no latch is inferred.
    always_comb begin
        run     = 1'b1;
        n       = '0;
        lane_en = '0;
        for (int j = 0; j < RETIRE_WIDTH; j++) begin
            run        = run && ready_bits[rob_add(head, j)] && (rob_cnt_t'(j) < count);
            lane_en[j] = run;
            if (run) n = n + 1'b1;
        end
    end

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates FETCH_WIDTH slots per group, tracks completion,
// retires up to RETIRE_WIDTH entries per cycle and returns their old aliases as freed registers.
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ALIAS_W*FETCH_WIDTH-1:0]      alloc_aliases,
    input  logic [FETCH_WIDTH-1:0]              alloc_slot_valid,
    input  logic                                alloc_valid,
    output logic                                alloc_ready,
    output logic [FETCH_WIDTH*ROB_ADDR_W-1:0]   rob_entries,
    input  logic [CMPLT_PORTS-1:0]              cmplt_valid,
    input  logic [CMPLT_PORTS*ROB_ADDR_W-1:0]   cmplt_idx,
    output logic [ALIAS_W*RETIRE_WIDTH-1:0]     free_regs,
    output logic                                rob_empty
);

    localparam rob_cnt_t ALLOC_LIMIT = rob_cnt_t'(ROB_DEPTH - FETCH_WIDTH);
    localparam rob_cnt_t GROUP_CNT   = rob_cnt_t'(FETCH_WIDTH);

    rob_idx_t                head;
    rob_idx_t                tail;
    rob_cnt_t                count;
    logic [ROB_DEPTH-1:0]    valid;
    logic [ROB_DEPTH-1:0]    done;
    alias_pair_t             alias_mem [ROB_DEPTH];
    ret_cnt_t                ret_n;
    logic [RETIRE_WIDTH-1:0] lane_en;
    logic                    fire;

    // Same-cycle retires are deliberately not credited, keeping alloc_ready off the retire path.
    assign alloc_ready = (count <= ALLOC_LIMIT) && !rst;
    assign fire        = alloc_valid && alloc_ready;
    assign rob_empty   = (count == '0);

    always_comb begin
        rob_entries = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            rob_entries[i*ROB_ADDR_W +: ROB_ADDR_W] = rob_add(tail, i);
    end

    retire_select u_select (
        .ready_bits (valid & done),
        .head       (head),
        .count      (count),
        .n          (ret_n),
        .lane_en    (lane_en)
    );

    // NOTE: later non-blocking writes to the same bit win, so the order below is the priority:
    // completion, then retire clear, then allocation (allocation beats a stale completion).
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            for (int p = 0; p < CMPLT_PORTS; p++)
                if (cmplt_valid[p] && valid[cmplt_idx[p*ROB_ADDR_W +: ROB_ADDR_W]])
                    done[cmplt_idx[p*ROB_ADDR_W +: ROB_ADDR_W]] <= 1'b1;
            for (int j = 0; j < RETIRE_WIDTH; j++)
                if (lane_en[j]) begin
                    valid[rob_add(head, j)] <= 1'b0;
                    done[rob_add(head, j)]  <= 1'b0;
                end
            if (fire) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    valid[rob_add(tail, i)] <= 1'b1;
                    done[rob_add(tail, i)]  <= !alloc_slot_valid[i];
                end
                tail <= rob_add(tail, FETCH_WIDTH);
            end
            head  <= head + rob_idx_t'(ret_n);
            count <= count + (fire ? GROUP_CNT : rob_cnt_t'(0)) - rob_cnt_t'(ret_n);
        end
    end

    // NOTE: alias storage has no reset; an entry is only read after its valid bit was set by a write.
    always_ff @(posedge clk) begin
        if (fire)
            for (int i = 0; i < FETCH_WIDTH; i++)
                alias_mem[rob_add(tail, i)] <= alloc_slot_valid[i]
                    ? alloc_aliases[i*ALIAS_W +: ALIAS_W] : PR_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_regs <= '0;
        end else begin
            for (int j = 0; j < RETIRE_WIDTH; j++)
                free_regs[j*ALIAS_W +: ALIAS_W] <= lane_en[j] ? alias_mem[rob_add(head, j)] : PR_NONE;
        end
    end

endmodule
